cpu_bus_responder: RTL and testbench

Target side of the CPU byte-wide memory bus. It decodes the address, data-out and write strobe driven by the CPU, serves the on-chip RAM with one-cycle read latency, and implements the I/O window at 0x30000+. The I/O window holds a UART TX FIFO, a UART RX byte port, a cycle counter and a program-stop latch. It also drives io_buffer_full back to the CPU.

---
 rtl/cpu_bus_responder.sv | 149 ++++++++++++++
 tb/tb_cpu_bus_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder.sv
// Target side of the CPU byte-wide memory bus: on-chip RAM plus an I/O window at 0x30000
// holding the UART TX FIFO, the UART RX byte port, a cycle counter and a program-stop latch.
module cpu_bus_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_end,
    output logic        tx_overflow
);
    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int CW    = TX_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

    logic [7:0] ram_q [2**RAM_ADDR_W];
    logic [7:0] fifo_q [DEPTH];

    logic [7:0]               mem_din_q, mem_din_d;
    logic                     rx_pop_q, rx_pop_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [31:0]              snap_q, snap_d;
    logic [TX_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [TX_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     buf_full_q, buf_full_d;
    logic                     program_end_q, program_end_d;
    logic                     overflow_q, overflow_d;

    logic                  is_io;
    logic [15:0]           io_off;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic                  bus_wr, bus_rd, ram_we;
    logic                  wr_tx, wr_end, push, push_ok, pop, fifo_full;
    logic [7:0]            push_byte;
    logic                  unused_addr_bits;

    assign is_io            = (mem_a[17:16] == 2'b11);
    assign io_off           = mem_a[15:0];
    assign ram_addr         = mem_a[RAM_ADDR_W-1:0];
    assign unused_addr_bits = ^mem_a[31:18];

    assign bus_wr    = rdy_in && mem_wr;
    assign bus_rd    = rdy_in && !mem_wr;
    assign ram_we    = bus_wr && !is_io;
    assign wr_tx     = bus_wr && is_io && (io_off == 16'h0000) && (mem_dout != 8'h00);
    assign wr_end    = bus_wr && is_io && (io_off == 16'h0004);
    assign push      = wr_tx || wr_end;
    assign push_byte = wr_end ? 8'h00 : mem_dout;

    assign fifo_full = (count_q == DEPTH_C);
    assign pop       = (count_q != '0) && tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push && (!fifo_full || pop);

    always_comb begin
        cnt_d         = rdy_in ? cnt_q + 32'd1 : cnt_q;
        wr_ptr_d      = push_ok ? wr_ptr_q + TX_DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + TX_DEPTH_LOG2'(1) : rd_ptr_q;
        count_d       = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        buf_full_d    = (DEPTH_C - count_d) <= MARGIN_C;
        overflow_d    = overflow_q || (push && fifo_full && !pop);
        program_end_d = program_end_q || wr_end;

        mem_din_d = mem_din_q;
        rx_pop_d  = 1'b0;
        snap_d    = snap_q;
        if (bus_rd) begin
            if (!is_io) begin
                mem_din_d = ram_q[ram_addr];
            end else begin
                unique case (io_off)
                    16'h0000: begin
                        mem_din_d = rx_valid ? rx_data : 8'h00;
                        rx_pop_d  = rx_valid;
                    end
                    16'h0004: begin
                        snap_d    = cnt_q;
                        mem_din_d = cnt_q[7:0];
                    end
                    16'h0005: mem_din_d = snap_q[15:8];
                    16'h0006: mem_din_d = snap_q[23:16];
                    16'h0007: mem_din_d = snap_q[31:24];
                    default:  mem_din_d = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_din_q     <= 8'h00;
            rx_pop_q      <= 1'b0;
            cnt_q         <= '0;
            snap_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            buf_full_q    <= 1'b0;
            program_end_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            mem_din_q     <= mem_din_d;
            rx_pop_q      <= rx_pop_d;
            cnt_q         <= cnt_d;
            snap_q        <= snap_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            buf_full_q    <= buf_full_d;
            program_end_q <= program_end_d;
            overflow_q    <= overflow_d;
        end
    end

    // Storage arrays are never cleared; writes are simply suppressed while in reset.
    always_ff @(posedge clk_in) begin
        if (rst_in && ram_we) ram_q[ram_addr] <= mem_dout;
        if (rst_in && push_ok) fifo_q[wr_ptr_q] <= push_byte;
    end

    assign mem_din        = mem_din_q;
    assign rx_pop         = rx_pop_q;
    assign io_buffer_full = buf_full_q;
    assign tx_valid       = (count_q != '0);
    assign tx_data        = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;
    assign program_end    = program_end_q;
    assign tx_overflow    = overflow_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: RAM, TX FIFO, RX port, cycle counter, program stop.
module tb_cpu_bus_responder;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, mem_wr, tx_ready, rx_valid;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, rx_data;
    logic [7:0]  mem_din, tx_data;
    logic        io_buffer_full, tx_valid, rx_pop, program_end, tx_overflow;
    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    cpu_bus_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .program_end(program_end), .tx_overflow(tx_overflow)
    );

    // Drive one bus cycle from a falling edge; returns at the next falling edge.
    task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic w, input logic r);
        mem_a = a; mem_dout = d; mem_wr = w; rdy_in = r;
        @(negedge clk_in);
    endtask

    task automatic idle();
        cyc(32'h0003_0010, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        cyc(32'h0003_0010, 8'h00, 1'b0, 1'b0);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        cyc(32'h0, 8'h00, 1'b0, 1'b0);
        cyc(32'h0, 8'h00, 1'b0, 1'b0);
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rst_mem_din got %h exp 00", mem_din); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", tx_data); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL rst_buf_full got %b exp 0", io_buffer_full); end
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rst_rx_pop got %b exp 0", rx_pop); end
        checks++; if (program_end !== 1'b0) begin errors++; $display("FAIL rst_program_end got %b exp 0", program_end); end
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", tx_overflow); end
        rst_in = 1'b1;
    endtask

    task automatic test_ram();
        cyc(32'h0000_0010, 8'hA5, 1'b1, 1'b1);
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL ram_wr_cycle got %h exp 00", mem_din); end
        cyc(32'h0000_0010, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_rd got %h exp a5", mem_din); end
        cyc(32'h0000_0010, 8'h5A, 1'b1, 1'b0);
        idle();
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL ram_idle got %h exp 00", mem_din); end
        cyc(32'h0000_0010, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_rdy_low_wr got %h exp a5", mem_din); end
        cyc(32'h0000_0011, 8'h77, 1'b1, 1'b1);
        cyc(32'h0000_0011, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'h77) begin errors++; $display("FAIL ram_b2b got %h exp 77", mem_din); end
        cyc(32'h0000_0010, 8'h00, 1'b0, 1'b0);
        checks++; if (mem_din !== 8'h77) begin errors++; $display("FAIL ram_rdy_low_hold got %h exp 77", mem_din); end
    endtask

    task automatic test_tx_basic();
        tx_ready = 1'b1;
        cyc(32'h0003_0000, 8'h48, 1'b1, 1'b1);
        checks++; if (tx_data !== 8'h48) begin errors++; $display("FAIL tx_h got %h exp 48", tx_data); end
        cyc(32'h0003_0000, 8'h00, 1'b1, 1'b1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_zero_dropped got %b exp 0", tx_valid); end
        cyc(32'h0003_0000, 8'h69, 1'b1, 1'b1);
        checks++; if (tx_data !== 8'h69) begin errors++; $display("FAIL tx_i got %h exp 69", tx_data); end
        idle();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty got %b exp 0", tx_valid); end
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL tx_basic_ovf got %b exp 0", tx_overflow); end
    endtask

    task automatic test_fifo_full();
        tx_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc(32'h0003_0000, 8'(k), 1'b1, 1'b1);
            checks++; if (io_buffer_full !== (k >= 6)) begin errors++; $display("FAIL full_flag push %0d got %b", k, io_buffer_full); end
            checks++; if (tx_overflow !== (k >= 9)) begin errors++; $display("FAIL overflow push %0d got %b", k, tx_overflow); end
        end
        tx_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(j)) begin errors++; $display("FAIL drain_%0d got v=%b d=%h exp %h", j, tx_valid, tx_data, 8'(j)); end
            idle();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", tx_valid); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL drain_full_flag got %b exp 0", io_buffer_full); end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        tx_ready = 1'b0;
        for (int k = 0; k < 8; k++) cyc(32'h0003_0000, 8'(8'h11 + k), 1'b1, 1'b1);
        checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL pp_full_flag got %b exp 1", io_buffer_full); end
        tx_ready = 1'b1;
        cyc(32'h0003_0000, 8'h19, 1'b1, 1'b1);
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL pp_no_overflow got %b exp 0", tx_overflow); end
        for (int j = 0; j < 8; j++) begin
            checks++; if (tx_data !== 8'(8'h12 + j)) begin errors++; $display("FAIL pp_drain_%0d got %h exp %h", j, tx_data, 8'(8'h12 + j)); end
            idle();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %b exp 0", tx_valid); end
    endtask

    task automatic test_rx();
        rx_valid = 1'b1; rx_data = 8'h3C;
        cyc(32'h0003_0000, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL rx_data got %h exp 3c", mem_din); end
        checks++; if (rx_pop !== 1'b1) begin errors++; $display("FAIL rx_pop got %b exp 1", rx_pop); end
        rx_valid = 1'b0;
        cyc(32'h0003_0000, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_empty_data got %h exp 00", mem_din); end
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_empty_pop got %b exp 0", rx_pop); end
        rx_valid = 1'b1; rx_data = 8'h5A;
        cyc(32'h0003_0000, 8'h00, 1'b0, 1'b0);
        checks++; if (rx_pop !== 1'b0 || mem_din !== 8'h00) begin errors++; $display("FAIL rx_rdy_low got pop=%b d=%h exp 0/00", rx_pop, mem_din); end
        rx_valid = 1'b0;
    endtask

    task automatic test_counter();
        do_reset();
        for (int i = 0; i < 600; i++) idle();
        for (int i = 0; i < 50; i++) cyc(32'h0003_0010, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) idle();
        cyc(32'h0003_0004, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'hE8) begin errors++; $display("FAIL cnt_b0 got %h exp e8", mem_din); end
        cyc(32'h0003_0005, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'h03) begin errors++; $display("FAIL cnt_b1 got %h exp 03", mem_din); end
        cyc(32'h0003_0006, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL cnt_b2 got %h exp 00", mem_din); end
        cyc(32'h0003_0007, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL cnt_b3 got %h exp 00", mem_din); end
    endtask

    task automatic test_counter_wrap();
        rdy_in = 1'b0;
        force dut.cnt_q = 32'hFFFF_FFFD;
        @(posedge clk_in);
        #1;
        release dut.cnt_q;
        @(negedge clk_in);
        cyc(32'h0003_0004, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'hFD) begin errors++; $display("FAIL wrap_b0 got %h exp fd", mem_din); end
        cyc(32'h0003_0005, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'hFF) begin errors++; $display("FAIL wrap_b1 got %h exp ff", mem_din); end
        cyc(32'h0003_0006, 8'h00, 1'b0, 1'b1);
        cyc(32'h0003_0007, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'hFF) begin errors++; $display("FAIL wrap_b3 got %h exp ff", mem_din); end
        cyc(32'h0003_0004, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'h01) begin errors++; $display("FAIL wrap_after_b0 got %h exp 01", mem_din); end
        cyc(32'h0003_0007, 8'h00, 1'b0, 1'b1);
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL wrap_after_b3 got %h exp 00", mem_din); end
    endtask

    task automatic test_program_end();
        do_reset();
        tx_ready = 1'b1;
        cyc(32'h0003_0008, 8'h77, 1'b1, 1'b1);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL io_other_wr got %b exp 0", tx_valid); end
        cyc(32'h0003_0004, 8'h55, 1'b1, 1'b1);
        checks++; if (program_end !== 1'b1) begin errors++; $display("FAIL pe_set got %b exp 1", program_end); end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL pe_tx got v=%b d=%h exp 1/00", tx_valid, tx_data); end
        idle();
        checks++; if (tx_valid !== 1'b0 || program_end !== 1'b1) begin errors++; $display("FAIL pe_sticky got v=%b pe=%b exp 0/1", tx_valid, program_end); end
        tx_ready = 1'b0;
        for (int k = 0; k < 7; k++) cyc(32'h0003_0000, 8'(8'h41 + k), 1'b1, 1'b1);
        tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        cyc(32'h0003_0000, 8'h00, 1'b0, 1'b1);
        checks++; if (tx_data !== 8'h42 || rx_pop !== 1'b1 || io_buffer_full !== 1'b1) begin errors++; $display("FAIL pre_rst got d=%h pop=%b full=%b exp 42/1/1", tx_data, rx_pop, io_buffer_full); end
        rx_valid = 1'b0;
        rst_in = 1'b0;
        cyc(32'h0003_0000, 8'h44, 1'b1, 1'b1);
        checks++; if (mem_din !== 8'h00 || rx_pop !== 1'b0) begin errors++; $display("FAIL mid_rst_bus got d=%h pop=%b exp 00/0", mem_din, rx_pop); end
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || io_buffer_full !== 1'b0) begin errors++; $display("FAIL mid_rst_tx got v=%b d=%h full=%b exp 0/00/0", tx_valid, tx_data, io_buffer_full); end
        checks++; if (program_end !== 1'b0 || tx_overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky got pe=%b ovf=%b exp 0/0", program_end, tx_overflow); end
        rst_in = 1'b1;
        idle();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL post_rst_tx got %b exp 0", tx_valid); end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b0; mem_a = '0; mem_dout = '0; mem_wr = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        @(negedge clk_in);
        test_reset();
        test_ram();
        test_tx_basic();
        test_fifo_full();
        test_push_pop_full();
        test_rx();
        test_counter();
        test_counter_wrap();
        test_program_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
